// File: rtl/load_store_unit.sv
// Data-memory access stage: turns an ALU effective address into a word-addressed
// request/ready + rvalid bus transaction and returns aligned, extended load data.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  output logic        Stall,
  output logic [31:0] ReadData,
  output logic        AccessErr,
  output logic        BusReq,
  input  logic        BusReady,
  output logic        BusWe,
  output logic [31:0] BusAddr,
  output logic [3:0]  BusBe,
  output logic [31:0] BusWData,
  input  logic        BusRValid,
  input  logic [31:0] BusRData,
  output logic [1:0]  o_dbg_state
);

  // Bus handshake: a command transfers on a rising edge where BusReq & BusReady;
  // BusReq and its payload hold until then. A read response is the single cycle
  // with BusRValid high while waiting in RESP; BusRValid at any other time is ignored.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [31:0]        r_addr;
  logic [2:0]         r_funct3;
  logic               r_we;
  logic [3:0]         r_be;
  logic [31:0]        r_wdata;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_rdata;
  logic               r_err;

  logic               w_access;
  logic               w_f3_illegal;
  logic               w_misalign;
  logic               w_req_err;
  logic [3:0]         w_be_in;
  logic [31:0]        w_wdata_in;
  logic [31:0]        w_shifted;
  logic [31:0]        w_load_data;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_tmo;
  logic               w_set_err;
  logic               w_capture;

  assign w_access     = MemRead | MemWrite;
  assign w_f3_illegal = (Funct3 == 3'b011) | (Funct3 == 3'b110) | (Funct3 == 3'b111)
                      | (MemWrite & Funct3[2]);
  assign w_misalign   = ((Funct3[1:0] == 2'b01) & ALUResult[0])
                      | ((Funct3 == 3'b010) & (ALUResult[1:0] != 2'b00));
  assign w_req_err    = (MemRead & MemWrite) | w_f3_illegal | w_misalign;

  always_comb begin
    w_be_in    = 4'b1111;
    w_wdata_in = WriteData;
    case (Funct3[1:0])
      2'b00: begin
        w_be_in    = 4'b0001 << ALUResult[1:0];
        w_wdata_in = {4{WriteData[7:0]}};
      end
      2'b01: begin
        w_be_in    = 4'b0011 << ALUResult[1:0];
        w_wdata_in = {2{WriteData[15:0]}};
      end
      default: begin
        w_be_in    = 4'b1111;
        w_wdata_in = WriteData;
      end
    endcase
  end

  // Bring the addressed lane down to bit 0, then extend by size/sign.
  assign w_shifted = BusRData >> {r_addr[1:0], 3'b000};

  always_comb begin
    w_load_data = BusRData;
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b100:  w_load_data = {24'd0, w_shifted[7:0]};
      3'b001:  w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b101:  w_load_data = {16'd0, w_shifted[15:0]};
      default: w_load_data = BusRData;
    endcase
  end

  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_tmo     = (TIMEOUT != 0) && (w_cnt_inc == CNT_W'(TIMEOUT));

  always_comb begin
    w_next    = r_state;
    w_set_err = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_access) begin
          if (w_req_err) begin
            w_next    = S_DONE;
            w_set_err = 1'b1;
          end else begin
            w_next = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (BusReady) begin
          w_next = r_we ? S_DONE : S_RESP;
        end else if (w_tmo) begin
          w_next    = S_DONE;
          w_set_err = 1'b1;
        end
      end
      S_RESP: begin
        if (BusRValid) begin
          w_next    = S_DONE;
          w_capture = 1'b1;
        end else if (w_tmo) begin
          w_next    = S_DONE;
          w_set_err = 1'b1;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr   <= 32'd0;
      r_funct3 <= 3'd0;
      r_we     <= 1'b0;
      r_be     <= 4'd0;
      r_wdata  <= 32'd0;
    end else if (r_state == S_IDLE && w_next == S_REQ) begin
      r_addr   <= ALUResult;
      r_funct3 <= Funct3;
      r_we     <= MemWrite;
      r_be     <= w_be_in;
      r_wdata  <= MemWrite ? w_wdata_in : 32'd0;
    end
  end

  // Wait counter restarts on every entry to REQ or RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if ((w_next == S_REQ || w_next == S_RESP) && w_next != r_state) begin
      r_cnt <= '0;
    end else if (r_state == S_REQ || r_state == S_RESP) begin
      r_cnt <= w_cnt_inc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else if (w_next == S_DONE && r_state != S_DONE) begin
      r_err   <= w_set_err;
      r_rdata <= w_capture ? w_load_data : 32'd0;
    end else if (r_state == S_DONE) begin
      r_err   <= 1'b0;
      r_rdata <= 32'd0;
    end
  end

  // Reset gates Stall so the core is released the moment reset asserts.
  assign Stall       = w_access & (r_state != S_DONE) & ~reset;
  assign BusReq      = (r_state == S_REQ);
  assign BusWe       = BusReq & r_we;
  assign BusAddr     = BusReq ? {r_addr[31:2], 2'b00} : 32'd0;
  assign BusBe       = BusReq ? r_be : 4'd0;
  assign BusWData    = BusReq ? r_wdata : 32'd0;
  assign ReadData    = r_rdata;
  assign AccessErr   = r_err;
  assign o_dbg_state = r_state;

endmodule
